// File: rtl/pixel_rd_pkg.sv
// Shared types, widths and the pixel select helper for the SDRAM pixel read responder.
// Contents: rd_state_t FSM encoding, ADDR_W/PIX_W/MEM_DW/TAG_W widths, sel_pixel().
// Pixel order inside a 16-bit word: even byte address in [7:0], odd in [15:8].
package pixel_rd_pkg;

    localparam int ADDR_W = 23;
    localparam int PIX_W  = 8;
    localparam int MEM_DW = 2 * PIX_W;
    localparam int TAG_W  = ADDR_W - 1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        ISSUE,
        WAIT,
        RESP
    } rd_state_t;

    function automatic logic [PIX_W-1:0] sel_pixel(input logic [MEM_DW-1:0] word,
                                                   input logic              lsb);
        return lsb ? word[MEM_DW-1:PIX_W] : word[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/pixel_word_cache.sv
// One-word hit cache: tag/data/valid register with hit compare, load and invalidate.
// Ports: tag_in (lookup and load tag), load/load_word (fill), inv (clear), hit/word (result).
// Hit is combinational; an invalidate in the same cycle forces a miss and wins over a load.
module pixel_word_cache
    import pixel_rd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              load,
    input  logic [MEM_DW-1:0] load_word,
    input  logic              inv,
    output logic              hit,
    output logic [MEM_DW-1:0] word
);

    logic             valid;
    logic [TAG_W-1:0] tag;

    // Data is still written when inv coincides with load, so the in-flight
    // response can be taken from the word register while valid stays clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            word  <= '0;
        end else begin
            if (load) begin
                tag  <= tag_in;
                word <= load_word;
            end
            if (inv) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end
        end
    end

    assign hit = valid && !inv && (tag == tag_in);

endmodule

// File: rtl/sdram_pixel_read_responder.sv
// Pixel read responder: turns byte-pixel requests into 16-bit SDRAM word reads via a one-word cache.
// Ports: req_start/req_addr in, rsp_valid/rsp_data out, mem_rd_* to the controller, busy and sticky errors.
// Latency: hit 1 cycle after req_start, miss 1 cycle after mem_rd_valid; one pending slot, overflow drops.
module sdram_pixel_read_responder
    import pixel_rd_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_start,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              cache_inv,
    output logic              rsp_valid,
    output logic [PIX_W-1:0]  rsp_data,
    output logic              busy,
    output logic              err_overflow,
    output logic              err_timeout,
    output logic              mem_rd_req,
    output logic [TAG_W-1:0]  mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic              mem_rd_valid,
    input  logic [MEM_DW-1:0] mem_rd_data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT);

    rd_state_t         state, state_nxt;
    logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
    logic              pend_full, pend_full_nxt;
    logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              hit;
    logic [MEM_DW-1:0] cache_word;
    logic              cache_load;
    logic              tmo_hit;
    logic              done;
    logic              ovf_set;

    pixel_word_cache u_cache (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_in    (cur_addr[ADDR_W-1:1]),
        .load      (cache_load),
        .load_word (mem_rd_data),
        .inv       (cache_inv),
        .hit       (hit),
        .word      (cache_word)
    );

    // A data return in the same cycle the count expires still wins.
    assign tmo_hit     = (state == WAIT) && !mem_rd_valid && (tmo_cnt >= TMO_MAX);
    assign mem_rd_addr = cur_addr[ADDR_W-1:1];
    assign busy        = (state != IDLE) || pend_full;

    always_comb begin
        state_nxt     = state;
        cur_addr_nxt  = cur_addr;
        pend_full_nxt = pend_full;
        pend_addr_nxt = pend_addr;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        mem_rd_req    = 1'b0;
        cache_load    = 1'b0;
        done          = 1'b0;
        ovf_set       = 1'b0;

        case (state)
            IDLE: begin
                if (req_start) begin
                    cur_addr_nxt = req_addr;
                    state_nxt    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    rsp_valid = 1'b1;
                    rsp_data  = sel_pixel(cache_word, cur_addr[0]);
                    done      = 1'b1;
                end else begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_rd_req = 1'b1;
                if (mem_rd_ack) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rd_valid) begin
                    cache_load = 1'b1;
                    state_nxt  = RESP;
                end else if (tmo_hit) begin
                    rsp_valid = 1'b1;
                    done      = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = sel_pixel(cache_word, cur_addr[0]);
                done      = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        // On completion the pending entry is serviced first; a request
        // arriving in that same cycle refills the slot (or, with the slot
        // empty, goes straight to lookup) so ordering is preserved.
        if (done) begin
            if (pend_full) begin
                cur_addr_nxt  = pend_addr;
                state_nxt     = LOOKUP;
                pend_full_nxt = req_start;
                if (req_start) begin
                    pend_addr_nxt = req_addr;
                end
            end else if (req_start) begin
                cur_addr_nxt = req_addr;
                state_nxt    = LOOKUP;
            end else begin
                state_nxt = IDLE;
            end
        end else if (req_start && (state != IDLE)) begin
            if (!pend_full) begin
                pend_full_nxt = 1'b1;
                pend_addr_nxt = req_addr;
            end else begin
                ovf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur_addr     <= '0;
            pend_full    <= 1'b0;
            pend_addr    <= '0;
            tmo_cnt      <= '0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_nxt;
            cur_addr     <= cur_addr_nxt;
            pend_full    <= pend_full_nxt;
            pend_addr    <= pend_addr_nxt;
            err_overflow <= err_overflow | ovf_set;
            err_timeout  <= err_timeout | tmo_hit;
            // Counts cycles since ISSUE entry, saturating at the limit.
            if ((state == LOOKUP) && (state_nxt == ISSUE)) begin
                tmo_cnt <= '0;
            end else if (((state == ISSUE) || (state == WAIT)) && (tmo_cnt != TMO_MAX)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_pixel_read_responder.sv
// Directed bench for sdram_pixel_read_responder with a behavioural SDRAM read port.
// Each scenario task drives requests and checks responses against hand-derived values.
// Inputs change and outputs are sampled 1 time unit after the falling clock edge.
module tb_sdram_pixel_read_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_start;
    logic [22:0] req_addr;
    logic        cache_inv;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        busy;
    logic        err_overflow;
    logic        err_timeout;
    logic        mem_rd_req;
    logic [21:0] mem_rd_addr;
    logic        mem_rd_ack;
    logic        mem_rd_valid;
    logic [15:0] mem_rd_data;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory responder controls and observations.
    int          ack_dly = 0;
    int          val_dly = 1;
    bit          never_valid = 1'b0;
    bit          resp_busy = 1'b0;
    int          hs_cnt = 0;
    logic [21:0] last_rd_addr = '0;

    always #5 clk = ~clk;

    sdram_pixel_read_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_start    (req_start),
        .req_addr     (req_addr),
        .cache_inv    (cache_inv),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_ack   (mem_rd_ack),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data)
    );

    // Pixel p holds p[7:0]^A5, except word 0x8 which holds 0xBEEF.
    function automatic logic [15:0] mem_model(input logic [21:0] wa);
        logic [7:0] lo;
        if (wa == 22'h8) return 16'hBEEF;
        lo = {wa[6:0], 1'b0};
        return {lo ^ 8'hA4, lo ^ 8'hA5};
    endfunction

    function automatic logic [7:0] exp_pix(input logic [22:0] p);
        logic [15:0] w;
        w = mem_model(p[22:1]);
        return p[0] ? w[15:8] : w[7:0];
    endfunction

    initial begin
        mem_rd_ack   = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_rd_req === 1'b1) begin
                resp_busy = 1'b1;
                repeat (ack_dly) @(negedge clk);
                mem_rd_ack   = 1'b1;
                last_rd_addr = mem_rd_addr;
                hs_cnt++;
                @(negedge clk);
                mem_rd_ack = 1'b0;
                if (!never_valid) begin
                    repeat (val_dly - 1) @(negedge clk);
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = mem_model(last_rd_addr);
                    @(negedge clk);
                    mem_rd_valid = 1'b0;
                end
                resp_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [22:0] a);
        req_start = 1'b1;
        req_addr  = a;
        tick();
        req_start = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic settle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || resp_busy) && n < 400) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_start = 1'b0; req_addr = '0; cache_inv = 1'b0;
        repeat (3) tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (mem_rd_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_rd_req: got %b want 0", mem_rd_req); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({err_overflow, err_timeout} !== 2'b00) begin n_bad++; $display("FAIL reset_errs: got %b want 00", {err_overflow, err_timeout}); end
        n_cmp++; if (mem_rd_addr !== 22'h0) begin n_bad++; $display("FAIL reset_mem_rd_addr: got %h want 0", mem_rd_addr); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_miss_hit();
        int n, h0, gap;
        bit prev_vld;
        ack_dly = 2; val_dly = 3;
        pulse_req(23'h000010);
        n = 0;
        while (mem_rd_req !== 1'b1 && n < 20) begin tick(); n++; end
        n_cmp++; if (mem_rd_addr !== 22'h000008) begin n_bad++; $display("FAIL miss_rd_addr: got %h want 000008", mem_rd_addr); end
        prev_vld = 1'b0; gap = 0;
        while (rsp_valid !== 1'b1 && gap < 60) begin prev_vld = mem_rd_valid; tick(); gap++; end
        n_cmp++; if (rsp_valid !== 1'b1 || prev_vld !== 1'b1) begin n_bad++; $display("FAIL miss_rsp_timing: rsp_valid %b prev mem_rd_valid %b want 1 1", rsp_valid, prev_vld); end
        n_cmp++; if (rsp_data !== 8'hEF) begin n_bad++; $display("FAIL miss_rsp_data: got %h want ef", rsp_data); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL miss_rsp_single: got %b want 0", rsp_valid); end
        settle();
        h0 = hs_cnt;
        pulse_req(23'h000011);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hBE) begin n_bad++; $display("FAIL hit_rsp: valid %b data %h want 1 be", rsp_valid, rsp_data); end
        n_cmp++; if (mem_rd_req !== 1'b0) begin n_bad++; $display("FAIL hit_no_req: got %b want 0", mem_rd_req); end
        settle();
        n_cmp++; if (hs_cnt !== h0) begin n_bad++; $display("FAIL hit_hs_cnt: got %0d want %0d", hs_cnt, h0); end
    endtask

    task automatic test_stream();
        int n, h0, got, bad_pix;
        ack_dly = 0; val_dly = 1;
        cache_inv = 1'b1; tick(); cache_inv = 1'b0;
        h0 = hs_cnt; got = 0; bad_pix = 0;
        for (int i = 0; i < 20; i++) begin
            pulse_req(23'(i));
            wait_rsp(n);
            if (rsp_valid === 1'b1) begin
                got++;
                if (rsp_data !== exp_pix(23'(i))) bad_pix++;
            end
            tick();
        end
        settle();
        n_cmp++; if (got !== 20) begin n_bad++; $display("FAIL stream_rsp_count: got %0d want 20", got); end
        n_cmp++; if (bad_pix !== 0) begin n_bad++; $display("FAIL stream_pixels: %0d wrong pixels want 0", bad_pix); end
        n_cmp++; if (hs_cnt - h0 !== 10) begin n_bad++; $display("FAIL stream_handshakes: got %0d want 10", hs_cnt - h0); end
    endtask

    task automatic test_back_to_back();
        int n, h0, got;
        logic [7:0] d [2];
        ack_dly = 1; val_dly = 4;
        n_cmp++; if (err_overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf_pre: got %b want 0", err_overflow); end
        h0 = hs_cnt;
        pulse_req(23'h100);
        n = 0;
        while (hs_cnt == h0 && n < 20) begin tick(); n++; end
        tick();
        pulse_req(23'h102);
        pulse_req(23'h104);
        got = 0; d[0] = '0; d[1] = '0;
        for (int k = 0; k < 120; k++) begin
            if (rsp_valid === 1'b1) begin
                if (got < 2) d[got] = rsp_data;
                got++;
            end
            tick();
        end
        n_cmp++; if (got !== 2) begin n_bad++; $display("FAIL b2b_rsp_count: got %0d want 2", got); end
        n_cmp++; if (d[0] !== exp_pix(23'h100)) begin n_bad++; $display("FAIL b2b_first: got %h want %h", d[0], exp_pix(23'h100)); end
        n_cmp++; if (d[1] !== exp_pix(23'h102)) begin n_bad++; $display("FAIL b2b_second: got %h want %h", d[1], exp_pix(23'h102)); end
        n_cmp++; if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL b2b_ovf: got %b want 1", err_overflow); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: busy %b want 0", busy); end
        settle();
    endtask

    task automatic test_timeout();
        int n;
        ack_dly = 0; never_valid = 1'b1;
        n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_pre: got %b want 0", err_timeout); end
        pulse_req(23'h200);
        n = 0;
        while (mem_rd_req !== 1'b1 && n < 20) begin tick(); n++; end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 400) begin tick(); n++; end
        n_cmp++; if (n !== 255) begin n_bad++; $display("FAIL tmo_cycles: got %0d want 255", n); end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h00) begin n_bad++; $display("FAIL tmo_rsp: valid %b data %h want 1 00", rsp_valid, rsp_data); end
        tick();
        n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL tmo_flag: got %b want 1", err_timeout); end
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_idle: busy %b rsp_valid %b want 0 0", busy, rsp_valid); end
        never_valid = 1'b0;
        settle();
    endtask

    task automatic test_reset_mid_wait();
        int n, h0, spur;
        ack_dly = 0; val_dly = 1;
        pulse_req(23'h40); wait_rsp(n); tick(); settle();
        pulse_req(23'h41);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== exp_pix(23'h41)) begin n_bad++; $display("FAIL rst_prehit: valid %b data %h want 1 %h", rsp_valid, rsp_data, exp_pix(23'h41)); end
        settle();
        val_dly = 20; h0 = hs_cnt;
        pulse_req(23'h42);
        n = 0;
        while (hs_cnt == h0 && n < 20) begin tick(); n++; end
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({rsp_valid, mem_rd_req, busy} !== 3'b000) begin n_bad++; $display("FAIL rst_outputs: rsp_valid/req/busy %b want 000", {rsp_valid, mem_rd_req, busy}); end
        n_cmp++; if ({err_overflow, err_timeout} !== 2'b00) begin n_bad++; $display("FAIL rst_errs: got %b want 00", {err_overflow, err_timeout}); end
        tick(); tick();
        rst_n = 1'b1;
        spur = 0; n = 0;
        while (resp_busy && n < 60) begin if (rsp_valid === 1'b1) spur++; tick(); n++; end
        tick();
        n_cmp++; if (spur !== 0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_ignore_valid: spurious %0d busy %b want 0 0", spur, busy); end
        val_dly = 1; h0 = hs_cnt;
        pulse_req(23'h41);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_cache_miss: rsp_valid %b want 0", rsp_valid); end
        wait_rsp(n);
        n_cmp++; if (rsp_data !== exp_pix(23'h41) || hs_cnt !== h0 + 1) begin n_bad++; $display("FAIL rst_refetch: data %h hs %0d want %h %0d", rsp_data, hs_cnt, exp_pix(23'h41), h0 + 1); end
        settle();
    endtask

    task automatic test_invalidate();
        int n, h0;
        ack_dly = 0; val_dly = 1;
        pulse_req(23'h000020); wait_rsp(n);
        n_cmp++; if (rsp_data !== exp_pix(23'h20)) begin n_bad++; $display("FAIL inv_fill: got %h want %h", rsp_data, exp_pix(23'h20)); end
        settle();
        pulse_req(23'h000021);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL inv_prehit: rsp_valid %b want 1", rsp_valid); end
        settle();
        cache_inv = 1'b1; tick(); cache_inv = 1'b0;
        h0 = hs_cnt;
        pulse_req(23'h000021);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL inv_miss: rsp_valid %b want 0", rsp_valid); end
        wait_rsp(n);
        n_cmp++; if (hs_cnt !== h0 + 1 || last_rd_addr !== 22'h000010) begin n_bad++; $display("FAIL inv_reissue: hs %0d addr %h want %0d 000010", hs_cnt, last_rd_addr, h0 + 1); end
        n_cmp++; if (rsp_data !== exp_pix(23'h21)) begin n_bad++; $display("FAIL inv_data: got %h want %h", rsp_data, exp_pix(23'h21)); end
        settle();
        // Invalidate landing in the lookup cycle of a would-be hit.
        pulse_req(23'h000020);
        cache_inv = 1'b1;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL inv_lookup_miss: rsp_valid %b want 0", rsp_valid); end
        tick();
        cache_inv = 1'b0;
        wait_rsp(n);
        n_cmp++; if (hs_cnt !== h0 + 2 || rsp_data !== exp_pix(23'h20)) begin n_bad++; $display("FAIL inv_lookup_fetch: hs %0d data %h want %0d %h", hs_cnt, rsp_data, h0 + 2, exp_pix(23'h20)); end
        settle();
    endtask

    initial begin
        test_reset();
        test_miss_hit();
        test_stream();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        test_invalidate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_pixel_read_responder.md
Name: sdram_pixel_read_responder

Overview:
- Responder end of the pixel read interface: requester pulses `req_start` with a 23-bit byte-pixel address and receives one 8-bit pixel on `rsp_data` / `rsp_valid`.
- Translates requests into 16-bit word reads on the SDRAM controller read port; each word holds two pixels.
- Keeps a one-word hit cache so sequential pixel streams (e.g. 20-pixel block rows) cost one SDRAM read per two pixels.
- Sits between the resize/averaging engines and the SDRAM controller.

Parameters:
- ADDR_W, 23, pixel (byte) address width.
- PIX_W, 8, pixel width.
- MEM_DW, 16, SDRAM word width; fixed at 2*PIX_W.
- TIMEOUT, 255, max cycles to wait for mem_rd_valid before aborting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_start  in  1  single-cycle read request strobe
- req_addr  in  ADDR_W  pixel address; sampled when req_start=1
- cache_inv  in  1  invalidate hit cache (frame swap)
- rsp_valid  out  1  single-cycle pulse; rsp_data valid
- rsp_data  out  PIX_W  returned pixel
- busy  out  1  high while any request is held or in flight
- err_overflow  out  1  sticky; request dropped
- err_timeout  out  1  sticky; SDRAM read timed out
- mem_rd_req  out  1  word read request; held until acked
- mem_rd_addr  out  ADDR_W-1  word address = req_addr[ADDR_W-1:1]
- mem_rd_ack  in  1  controller accepted mem_rd_req
- mem_rd_valid  in  1  mem_rd_data valid, one-cycle pulse
- mem_rd_data  in  MEM_DW  returned word

Behaviour:
- Reset is asynchronous and active-low. All outputs go to 0, the cache valid bit goes to 0, the pending slot is emptied, and the FSM goes to IDLE.
- Pixel select: addr[0]=0 selects word[7:0]; addr[0]=1 selects word[15:8].
- FSM states: IDLE, LOOKUP, ISSUE, WAIT, RESP.
- IDLE: on req_start, latch the address, go to LOOKUP.
- LOOKUP (1 cycle):
  - Hit means the cache is valid and the cached tag equals addr[22:1]. On a hit, drive rsp_data from the cached word and pulse rsp_valid in this same cycle. Latency is 1 cycle after req_start. Then go to IDLE, or to LOOKUP if the pending slot is full.
  - On a miss, go to ISSUE.
- ISSUE: assert mem_rd_req with mem_rd_addr held stable until the cycle mem_rd_ack=1, then go to WAIT.
- WAIT:
  - On mem_rd_valid, load the cache (tag and word), set it valid, go to RESP.
  - The timeout counter runs from ISSUE entry. When it reaches TIMEOUT, set err_timeout, return rsp_data=0 with rsp_valid=1, leave the cache invalid, and go to IDLE.
- RESP: pulse rsp_valid with the selected byte, one cycle after mem_rd_valid. Then go to IDLE, or to LOOKUP if the pending slot is full.
- Pending slot (one entry):
  - A req_start outside IDLE is stored here and serviced in order.
  - A req_start while the slot is full is dropped and err_overflow is set.
  - A req_start in the same cycle the slot drains is accepted.
- busy = (state != IDLE) OR pending full.
- cache_inv clears the valid bit in the cycle it is asserted.
  - If it coincides with LOOKUP, the request is treated as a miss.
  - If it coincides with the mem_rd_valid load in WAIT, the load wins for the in-flight request's response, but the cache is left invalid afterwards.
- rsp_valid is never asserted in two consecutive cycles for a single request. Each accepted request yields exactly one rsp_valid.
- A mem_rd_valid arriving outside WAIT is ignored.
- The error flags clear only on reset.

Decomposition:
- Package `pixel_rd_pkg`:
  - state enum `rd_state_t` (IDLE, LOOKUP, ISSUE, WAIT, RESP)
  - constants ADDR_W, PIX_W, MEM_DW
  - function `sel_pixel(word, lsb)`
- Natural sub-module `pixel_word_cache`: tag/data/valid register with hit compare, load, and invalidate. The top module holds the FSM, pending slot, and timeout counter.

Test Plan:
- Reset mid-WAIT: assert rst_n=0 → rsp_valid, mem_rd_req, busy, err_* all 0 immediately. The next request to an address whose word was previously cached is a miss.
- Miss then hit: req 0x000010 → mem_rd_addr=0x000008. Controller acks after 2 cycles and returns 0xBEEF three cycles later → rsp_data=0xEF one cycle after mem_rd_valid. Then req 0x000011 → rsp_data=0xBE the cycle after req_start, with no mem_rd_req.
- Streaming 20 pixels from 0x000000: one req per response → exactly 10 mem_rd_req handshakes and 20 rsp_valid pulses, each pixel matching the model.
- Back-to-back pressure: req 0x100 then req 0x102 during the first one's WAIT, then req 0x104 before either completes. Expect responses for 0x100 then 0x102, 0x104 dropped, and err_overflow=1.
- Timeout: ack but never assert mem_rd_valid → after 255 cycles rsp_valid=1, rsp_data=0x00, err_timeout=1, busy=0 on the following cycle.
- Invalidate: cache 0x000020, pulse cache_inv, then req 0x000021 → a new mem_rd_req to 0x000010 is issued.
